// File: rtl/pong_game_ctrl.sv
// Frame-rate Pong sequencer: on each VS falling edge it advances ball and paddles,
// resolves wall/paddle collisions, keeps score and sequences serve and game over.
module pong_game_ctrl #(
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int BALL_SIZE    = 10,
    parameter int PADDLE_H     = 40,
    parameter int PADDLE_L_X   = 20,
    parameter int PADDLE_R_X   = 610,
    parameter int BALL_SPEED   = 2,
    parameter int PADDLE_SPEED = 4,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 7
) (
    input  logic       iVGA_CLK,
    input  logic       iRST_n,
    input  logic       iVS,
    input  logic       iLeft_up,
    input  logic       iLeft_down,
    input  logic       iRight_up,
    input  logic       iRight_down,
    input  logic       iStart,
    output logic [9:0] ball_x,
    output logic [8:0] ball_y,
    output logic [8:0] paddle_left_y,
    output logic [8:0] paddle_right_y,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic       game_over
);

    localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

    localparam logic [9:0]  BALL_X0 = 10'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [8:0]  BALL_Y0 = 9'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [8:0]  PAD_Y0  = 9'((SCREEN_H - PADDLE_H) / 2);
    localparam logic [10:0] PAD_MAX = 11'(SCREEN_H - PADDLE_H);
    localparam logic [10:0] BY_MAX  = 11'(SCREEN_H - BALL_SIZE);
    localparam logic [10:0] BX_MAX  = 11'(SCREEN_W - BALL_SIZE);
    localparam logic [10:0] L_FACE  = 11'(PADDLE_L_X + 10);
    localparam logic [10:0] R_FACE  = 11'(PADDLE_R_X);
    localparam logic [10:0] BSZ     = 11'(BALL_SIZE);
    localparam logic [10:0] PH      = 11'(PADDLE_H);
    localparam logic [10:0] BSP     = 11'(BALL_SPEED);
    localparam logic [10:0] PSP     = 11'(PADDLE_SPEED);

    typedef enum logic [1:0] {S_SERVE, S_PLAY, S_POINT, S_OVER} state_t;

    state_t           state;
    logic             vs_d;
    logic             dx_right;
    logic             dy_down;
    logic             scorer_right;
    logic [CNT_W-1:0] serve_cnt;

    logic        tick;
    logic [10:0] bx, by, pl, pr;
    logic [8:0]  pl_next, pr_next, by_next;
    logic [9:0]  bx_next;
    logic        dx_next, dy_next;
    logic        ovl_l, ovl_r;
    logic        point_l, point_r;
    logic [3:0]  pt_score;
    logic        pt_win;

    function automatic logic [8:0] paddle_step(input logic [8:0] y, input logic up, input logic down);
        logic [10:0] w;
        w = {2'b00, y};
        paddle_step = y;
        if (up && !down)
            paddle_step = (w < PSP) ? '0 : y - PSP[8:0];
        else if (down && !up)
            paddle_step = (w + PSP > PAD_MAX) ? PAD_MAX[8:0] : y + PSP[8:0];
    endfunction

    // Collision tests run at 11 bits so edge + size + speed cannot wrap.
    always_comb begin
        tick    = vs_d & ~iVS;
        bx      = {1'b0, ball_x};
        by      = {2'b00, ball_y};
        pl      = {2'b00, paddle_left_y};
        pr      = {2'b00, paddle_right_y};
        pl_next = paddle_step(paddle_left_y, iLeft_up, iLeft_down);
        pr_next = paddle_step(paddle_right_y, iRight_up, iRight_down);
        ovl_l   = (by + BSZ > pl) && (by < pl + PH);
        ovl_r   = (by + BSZ > pr) && (by < pr + PH);

        by_next = ball_y;
        dy_next = dy_down;
        if (!dy_down) begin
            if (by < BSP) begin
                by_next = '0;
                dy_next = 1'b1;
            end else begin
                by_next = ball_y - BSP[8:0];
            end
        end else if (by + BSP > BY_MAX) begin
            by_next = BY_MAX[8:0];
            dy_next = 1'b0;
        end else begin
            by_next = ball_y + BSP[8:0];
        end

        bx_next = ball_x;
        dx_next = dx_right;
        point_l = 1'b0;
        point_r = 1'b0;
        if (!dx_right) begin
            if (bx >= L_FACE && bx - BSP < L_FACE && ovl_l) begin
                bx_next = L_FACE[9:0];
                dx_next = 1'b1;
            end else if (bx < BSP) begin
                point_r = 1'b1;
            end else begin
                bx_next = ball_x - BSP[9:0];
            end
        end else begin
            if (bx + BSZ <= R_FACE && bx + BSZ + BSP > R_FACE && ovl_r) begin
                bx_next = 10'(R_FACE - BSZ);
                dx_next = 1'b0;
            end else if (bx + BSP > BX_MAX) begin
                point_l = 1'b1;
            end else begin
                bx_next = ball_x + BSP[9:0];
            end
        end

        pt_score = (scorer_right ? score_right : score_left) + 4'd1;
        pt_win   = (pt_score == 4'(WIN_SCORE));
    end

    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            state          <= S_SERVE;
            serve_cnt      <= '0;
            vs_d           <= 1'b1;
            dx_right       <= 1'b1;
            dy_down        <= 1'b1;
            scorer_right   <= 1'b0;
            ball_x         <= BALL_X0;
            ball_y         <= BALL_Y0;
            paddle_left_y  <= PAD_Y0;
            paddle_right_y <= PAD_Y0;
            score_left     <= '0;
            score_right    <= '0;
            game_over      <= 1'b0;
        end else begin
            vs_d <= iVS;
            case (state)
                S_SERVE: begin
                    if (tick) begin
                        paddle_left_y  <= pl_next;
                        paddle_right_y <= pr_next;
                        if (serve_cnt == CNT_W'(SERVE_FRAMES - 1)) begin
                            serve_cnt <= '0;
                            state     <= S_PLAY;
                        end else begin
                            serve_cnt <= serve_cnt + 1'b1;
                        end
                    end
                end
                S_PLAY: begin
                    if (tick) begin
                        paddle_left_y  <= pl_next;
                        paddle_right_y <= pr_next;
                        ball_y         <= by_next;
                        dy_down        <= dy_next;
                        // A miss leaves x where it was; POINT decides where the ball goes.
                        if (point_l || point_r) begin
                            scorer_right <= point_r;
                            state        <= S_POINT;
                        end else begin
                            ball_x   <= bx_next;
                            dx_right <= dx_next;
                        end
                    end
                end
                S_POINT: begin
                    if (scorer_right)
                        score_right <= pt_score;
                    else
                        score_left <= pt_score;
                    if (pt_win) begin
                        game_over <= 1'b1;
                        state     <= S_OVER;
                    end else begin
                        ball_x    <= BALL_X0;
                        ball_y    <= BALL_Y0;
                        dx_right  <= ~scorer_right;
                        serve_cnt <= '0;
                        state     <= S_SERVE;
                    end
                end
                S_OVER: begin
                    if (iStart) begin
                        score_left  <= '0;
                        score_right <= '0;
                        ball_x      <= BALL_X0;
                        ball_y      <= BALL_Y0;
                        serve_cnt   <= '0;
                        game_over   <= 1'b0;
                        state       <= S_SERVE;
                    end
                end
                default: state <= S_SERVE;
            endcase
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: a cycle model feeds a scoreboard queue,
// plus directed checks for serve timing, saturation, win, restart and reset-on-tick.
module tb_pong_game_ctrl;

    logic       clk = 1'b0;
    logic       iRST_n, iVS, iLeft_up, iLeft_down, iRight_up, iRight_down, iStart;
    logic [9:0] ball_x;
    logic [8:0] ball_y, paddle_left_y, paddle_right_y;
    logic [3:0] score_left, score_right;
    logic       game_over;

    always #5 clk = ~clk;

    pong_game_ctrl #(.SERVE_FRAMES(60), .WIN_SCORE(7)) dut (
        .iVGA_CLK      (clk),
        .iRST_n        (iRST_n),
        .iVS           (iVS),
        .iLeft_up      (iLeft_up),
        .iLeft_down    (iLeft_down),
        .iRight_up     (iRight_up),
        .iRight_down   (iRight_down),
        .iStart        (iStart),
        .ball_x        (ball_x),
        .ball_y        (ball_y),
        .paddle_left_y (paddle_left_y),
        .paddle_right_y(paddle_right_y),
        .score_left    (score_left),
        .score_right   (score_right),
        .game_over     (game_over)
    );

    typedef struct packed {
        logic [9:0] bx;
        logic [8:0] by;
        logic [8:0] pl;
        logic [8:0] pr;
        logic [3:0] sl;
        logic [3:0] sr;
        logic       go;
    } obs_t;

    localparam int OW = $bits(obs_t);

    obs_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state (0 serve, 1 play, 2 point, 3 over)
    int m_st, m_bx, m_by, m_pl, m_pr, m_sl, m_sr, m_go, m_dxr, m_dyd, m_cnt, m_vsd, m_scr;
    int save_bx, save_by;

    function automatic obs_t mk(int bx, int by, int pl, int pr, int sl, int sr, int go);
        obs_t r;
        r.bx = 10'(bx); r.by = 9'(by); r.pl = 9'(pl); r.pr = 9'(pr);
        r.sl = 4'(sl);  r.sr = 4'(sr); r.go = 1'(go);
        return r;
    endfunction

    function automatic obs_t dut_obs();
        obs_t r;
        r.bx = ball_x; r.by = ball_y; r.pl = paddle_left_y; r.pr = paddle_right_y;
        r.sl = score_left; r.sr = score_right; r.go = game_over;
        return r;
    endfunction

    function automatic int pad_move(int y, logic up, logic dn);
        if (up && !dn) return (y - 4 < 0) ? 0 : y - 4;
        if (dn && !up) return (y + 4 > 440) ? 440 : y + 4;
        return y;
    endfunction

    task automatic check(input string tag, input logic [OW-1:0] o, input logic [OW-1:0] e);
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h at %0t", tag, o, e, $time);
        end
    endtask

    task automatic model_cycle(input logic rst_n, input logic vs, input logic lu, input logic ld,
                               input logic ru, input logic rd, input logic st);
        logic tk, ovl, ovr;
        int   nby, ndy;
        if (!rst_n) begin
            m_st = 0; m_bx = 315; m_by = 235; m_pl = 220; m_pr = 220; m_sl = 0; m_sr = 0;
            m_go = 0; m_dxr = 1; m_dyd = 1; m_cnt = 0; m_vsd = 1; m_scr = 0;
            return;
        end
        tk = (m_vsd == 1) && (vs == 1'b0);
        m_vsd = vs ? 1 : 0;
        case (m_st)
            0: if (tk) begin
                m_pl = pad_move(m_pl, lu, ld);
                m_pr = pad_move(m_pr, ru, rd);
                if (m_cnt == 59) begin m_cnt = 0; m_st = 1; end
                else m_cnt++;
            end
            1: if (tk) begin
                ovl = (m_by + 10 > m_pl) && (m_by < m_pl + 40);
                ovr = (m_by + 10 > m_pr) && (m_by < m_pr + 40);
                if (m_dyd == 1) begin
                    if (m_by + 2 > 470) begin nby = 470; ndy = 0; end
                    else begin nby = m_by + 2; ndy = 1; end
                end else begin
                    if (m_by < 2) begin nby = 0; ndy = 1; end
                    else begin nby = m_by - 2; ndy = 0; end
                end
                m_pl = pad_move(m_pl, lu, ld);
                m_pr = pad_move(m_pr, ru, rd);
                m_by = nby; m_dyd = ndy;
                if (m_dxr == 0) begin
                    if (m_bx >= 30 && m_bx - 2 < 30 && ovl) begin m_bx = 30; m_dxr = 1; end
                    else if (m_bx < 2) begin m_scr = 1; m_st = 2; end
                    else m_bx -= 2;
                end else begin
                    if (m_bx + 10 <= 610 && m_bx + 12 > 610 && ovr) begin m_bx = 600; m_dxr = 0; end
                    else if (m_bx + 2 > 630) begin m_scr = 0; m_st = 2; end
                    else m_bx += 2;
                end
            end
            2: begin
                if (m_scr == 1) m_sr++; else m_sl++;
                if (((m_scr == 1) ? m_sr : m_sl) == 7) begin m_go = 1; m_st = 3; end
                else begin
                    m_bx = 315; m_by = 235; m_dxr = (m_scr == 1) ? 0 : 1; m_cnt = 0; m_st = 0;
                end
            end
            default: if (st) begin
                m_sl = 0; m_sr = 0; m_bx = 315; m_by = 235; m_cnt = 0; m_go = 0; m_st = 0;
            end
        endcase
    endtask

    task automatic step(input logic rst_n, input logic vs, input logic lu, input logic ld,
                        input logic ru, input logic rd, input logic st);
        obs_t e;
        iRST_n = rst_n; iVS = vs; iLeft_up = lu; iLeft_down = ld;
        iRight_up = ru; iRight_down = rd; iStart = st;
        model_cycle(rst_n, vs, lu, ld, ru, rd, st);
        sb_q.push_back(mk(m_bx, m_by, m_pl, m_pr, m_sl, m_sr, m_go));
        @(negedge clk);
        e = sb_q.pop_front();
        check("cycle", dut_obs(), e);
    endtask

    // One video frame: a single VS-low cycle followed by three VS-high cycles.
    task automatic frame(input logic lu, input logic ld, input logic ru, input logic rd);
        step(1'b1, 1'b0, lu, ld, ru, rd, 1'b0);
        repeat (3) step(1'b1, 1'b1, lu, ld, ru, rd, 1'b0);
    endtask

    function automatic logic trk_up(int pad, int by);
        return pad + 20 > by + 7;
    endfunction

    function automatic logic trk_dn(int pad, int by);
        return pad + 20 < by + 3;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        iRST_n = 1'b0; iVS = 1'b1; iLeft_up = 1'b0; iLeft_down = 1'b0;
        iRight_up = 1'b0; iRight_down = 1'b0; iStart = 1'b0;

        repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_state", dut_obs(), mk(315, 235, 220, 220, 0, 0, 0));

        // Serve: 60 ticks hold the ball; paddles driven into both rails.
        repeat (60) frame(1'b1, 1'b0, 1'b0, 1'b1);
        check("serve_ball_held", OW'({ball_x, ball_y}), OW'({10'd315, 9'd235}));
        check("paddle_saturate", OW'({paddle_left_y, paddle_right_y}), OW'({9'd0, 9'd440}));
        frame(1'b1, 1'b1, 1'b1, 1'b1);
        check("first_play_move", OW'({ball_x, ball_y}), OW'({10'd317, 9'd237}));
        check("both_buttons_hold", OW'({paddle_left_y, paddle_right_y}), OW'({9'd0, 9'd440}));

        // Rally: both paddles track the ball so reflections on both faces occur.
        for (int f = 0; f < 600; f++)
            frame(trk_up(m_pl, m_by), trk_dn(m_pl, m_by), trk_up(m_pr, m_by), trk_dn(m_pr, m_by));

        // Left player dodges until the right player reaches the winning score.
        for (int f = 0; f < 6000 && m_go == 0; f++)
            frame(m_by + 5 >= 240, m_by + 5 < 240, trk_up(m_pr, m_by), trk_dn(m_pr, m_by));
        repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("win_score_right", OW'(score_right), OW'(4'd7));
        check("game_over_set", OW'(game_over), OW'(1'b1));

        save_bx = m_bx;
        save_by = m_by;
        repeat (5) frame(1'b1, 1'b0, 1'b0, 1'b1);
        check("over_ball_frozen", OW'({ball_x, ball_y}), OW'({10'(save_bx), 9'(save_by)}));

        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("restart", dut_obs(), mk(315, 235, m_pl, m_pr, 0, 0, 0));

        // Back into play, then reset coincident with a tick.
        repeat (65) frame(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("reset_on_tick", dut_obs(), mk(315, 235, 220, 220, 0, 0, 0));
        repeat (61) frame(1'b0, 1'b0, 1'b0, 1'b0);
        check("post_reset_dir", OW'({ball_x, ball_y}), OW'({10'd317, 9'd237}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
